// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and next-PC select codes for the 3-stage pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_REDIR = 2'b10,
    ST_MISS  = 2'b11
  } state_e;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_BR    = 2'b01;
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;
  localparam logic [1:0] PC_SEL_RST   = 2'b11;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Free-running cycle counter and retired-instruction counter read by the CSR path.
module perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cyc_en,
  input  logic             i_ret_en,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (i_cyc_en) r_cycle   <= r_cycle + CNT_W'(1);
      if (i_ret_en) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign o_cycle_cnt = r_cycle;
  assign o_instret   = r_instret;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables, bubbles and next-PC select for IF / ID-EX / WB,
// covering boot, redirect flush, load-use stall and data-memory miss freeze.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_stall_i,
  input  logic             dcache_stall_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_jal_i,
  input  logic             ex_is_jalr_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_br_taken_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             wb_valid_i,
  output logic [1:0]       pc_sel_o,
  output logic             if_en_o,
  output logic             ex_en_o,
  output logic             ex_bubble_o,
  output logic             wb_bubble_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o
);

  state_e r_state;
  state_e w_next_state;
  logic   r_ret_redir;
  logic   w_next_ret_redir;
  logic   w_redirect;
  logic   w_load_use;

  assign w_redirect = ex_valid_i &
                      (ex_is_jal_i | ex_is_jalr_i | (ex_is_branch_i & ex_br_taken_i));

  assign w_load_use = ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                      ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_BOOT;
      r_ret_redir <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ret_redir <= w_next_ret_redir;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_ret_redir = r_ret_redir;
    pc_sel_o         = PC_SEL_PLUS4;
    if_en_o          = 1'b0;
    ex_en_o          = 1'b0;
    ex_bubble_o      = 1'b0;
    wb_bubble_o      = 1'b0;

    case (r_state)
      ST_BOOT: begin
        pc_sel_o    = PC_SEL_RST;
        if_en_o     = ~icache_stall_i;
        ex_en_o     = 1'b1;
        ex_bubble_o = 1'b1;
        wb_bubble_o = 1'b1;
        if (!icache_stall_i) w_next_state = ST_RUN;
      end

      ST_RUN: begin
        if (dcache_stall_i) begin
          w_next_ret_redir = 1'b0;
          w_next_state     = ST_MISS;
        end else if (icache_stall_i && w_redirect) begin
          // Hold the redirecting instruction in EX until the fetch side can follow it.
          wb_bubble_o = 1'b1;
        end else if (icache_stall_i) begin
          ex_en_o     = 1'b1;
          ex_bubble_o = 1'b1;
        end else if (w_redirect) begin
          pc_sel_o     = ex_is_jalr_i ? PC_SEL_JALR : PC_SEL_BR;
          if_en_o      = 1'b1;
          ex_en_o      = 1'b1;
          ex_bubble_o  = 1'b1;
          w_next_state = ST_REDIR;
        end else if (w_load_use) begin
          ex_en_o     = 1'b1;
          ex_bubble_o = 1'b1;
        end else begin
          if_en_o = 1'b1;
          ex_en_o = 1'b1;
        end
      end

      ST_REDIR: begin
        // Squash the wrong-path fetch issued alongside the redirect.
        if (dcache_stall_i) begin
          w_next_ret_redir = 1'b1;
          w_next_state     = ST_MISS;
        end else begin
          if_en_o     = ~icache_stall_i;
          ex_en_o     = 1'b1;
          ex_bubble_o = 1'b1;
          if (!icache_stall_i) w_next_state = ST_RUN;
        end
      end

      ST_MISS: begin
        if (!dcache_stall_i) w_next_state = r_ret_redir ? ST_REDIR : ST_RUN;
      end
    endcase

    if (reset) begin
      pc_sel_o    = PC_SEL_RST;
      if_en_o     = 1'b0;
      ex_en_o     = 1'b0;
      ex_bubble_o = 1'b1;
      wb_bubble_o = 1'b1;
    end
  end

  assign state_o = r_state;

  perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_cyc_en    (1'b1),
    .i_ret_en    (wb_valid_i & ~dcache_stall_i),
    .o_cycle_cnt (cycle_cnt_o),
    .o_instret   (instret_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: reset, RUN vector table, multi-cycle sequences,
// counter wrap on a narrow build, and randomized traffic against a reference model.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, icache, dcache, exv, jal, jalr, br, tk, ld, u1, u2, wbv;
  logic [4:0] rd, rs1, rs2;
  logic [1:0]  pc_sel, state;
  logic        if_en, ex_en, ex_b, wb_b;
  logic [31:0] cyc, ret;

  logic       rst4;
  logic [1:0] pc4, st4;
  logic       if4, ex4, exb4, wbb4;
  logic [3:0] cyc4, ret4;

  pipe_ctrl u_dut (
    .clk(clk), .reset(reset), .icache_stall_i(icache), .dcache_stall_i(dcache),
    .ex_valid_i(exv), .ex_is_jal_i(jal), .ex_is_jalr_i(jalr), .ex_is_branch_i(br),
    .ex_br_taken_i(tk), .ex_is_load_i(ld), .ex_rd_i(rd), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_uses_rs1_i(u1), .id_uses_rs2_i(u2), .wb_valid_i(wbv), .pc_sel_o(pc_sel),
    .if_en_o(if_en), .ex_en_o(ex_en), .ex_bubble_o(ex_b), .wb_bubble_o(wb_b),
    .state_o(state), .cycle_cnt_o(cyc), .instret_o(ret)
  );

  pipe_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(rst4), .icache_stall_i(1'b0), .dcache_stall_i(1'b0),
    .ex_valid_i(1'b0), .ex_is_jal_i(1'b0), .ex_is_jalr_i(1'b0), .ex_is_branch_i(1'b0),
    .ex_br_taken_i(1'b0), .ex_is_load_i(1'b0), .ex_rd_i(5'd0), .id_rs1_i(5'd0),
    .id_rs2_i(5'd0), .id_uses_rs1_i(1'b0), .id_uses_rs2_i(1'b0), .wb_valid_i(1'b1),
    .pc_sel_o(pc4), .if_en_o(if4), .ex_en_o(ex4), .ex_bubble_o(exb4), .wb_bubble_o(wbb4),
    .state_o(st4), .cycle_cnt_o(cyc4), .instret_o(ret4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    icache = 0; dcache = 0; exv = 0; jal = 0; jalr = 0; br = 0; tk = 0; ld = 0;
    u1 = 0; u2 = 0; wbv = 0; rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] pc, input logic ie,
                         input logic ee, input logic eb, input logic wb);
    chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(pc));
    chk({tag, ".if_en"}, 32'(if_en), 32'(ie));
    chk({tag, ".ex_en"}, 32'(ex_en), 32'(ee));
    chk({tag, ".ex_bub"}, 32'(ex_b), 32'(eb));
    chk({tag, ".wb_bub"}, 32'(wb_b), 32'(wb));
  endtask

  // Reference model: pipeline mode as flags, outputs from the sequencing rules.
  bit          m_boot, m_kill, m_frozen, m_resume;
  logic [31:0] m_cyc, m_ret;
  logic [1:0]  e_pc;
  logic        e_if, e_ex, e_exb, e_wbb;

  function automatic bit m_redir();
    return exv && (jal || jalr || (br && tk));
  endfunction

  function automatic bit m_lu();
    return exv && ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  function automatic logic [1:0] m_state();
    if (m_boot) return 2'd0;
    if (m_frozen) return 2'd3;
    if (m_kill) return 2'd2;
    return 2'd1;
  endfunction

  function automatic void model_outputs();
    e_pc = 0; e_if = 0; e_ex = 0; e_exb = 0; e_wbb = 0;
    if (reset) begin
      e_pc = 3; e_exb = 1; e_wbb = 1;
    end else if (m_boot) begin
      e_pc = 3; e_if = !icache; e_ex = 1; e_exb = 1; e_wbb = 1;
    end else if (m_frozen || dcache) begin
      // frozen: everything stays zero
    end else if (m_kill) begin
      e_if = !icache; e_ex = 1; e_exb = 1;
    end else if (icache && m_redir()) begin
      e_wbb = 1;
    end else if (icache) begin
      e_ex = 1; e_exb = 1;
    end else if (m_redir()) begin
      e_pc = jalr ? 2'd2 : 2'd1; e_if = 1; e_ex = 1; e_exb = 1;
    end else if (m_lu()) begin
      e_ex = 1; e_exb = 1;
    end else begin
      e_if = 1; e_ex = 1;
    end
  endfunction

  function automatic void model_advance();
    if (reset) begin
      m_boot = 1; m_kill = 0; m_frozen = 0; m_resume = 0; m_cyc = 0; m_ret = 0;
      return;
    end
    m_cyc = m_cyc + 1;
    if (wbv && !dcache) m_ret = m_ret + 1;
    if (m_boot) begin
      if (!icache) m_boot = 0;
    end else if (m_frozen) begin
      if (!dcache) begin m_frozen = 0; m_kill = m_resume; end
    end else if (m_kill) begin
      if (dcache) begin m_frozen = 1; m_resume = 1; m_kill = 0; end
      else if (!icache) m_kill = 0;
    end else begin
      if (dcache) begin m_frozen = 1; m_resume = 0; end
      else if (!icache && m_redir()) m_kill = 1;
    end
  endfunction

  typedef struct {
    string      name;
    logic       icache, dcache, exv, jal, jalr, br, tk, ld;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic [1:0] pc;
    logic       ie, ee, eb, wb;
    logic [1:0] nst;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string n, logic ic, logic dc, logic v, logic j, logic jr,
                              logic b, logic t, logic l, logic [4:0] d, logic [4:0] s1,
                              logic [4:0] s2, logic a1, logic a2, logic [1:0] p,
                              logic ie, logic ee, logic eb, logic wb, logic [1:0] ns);
    vec_t x;
    x.name = n; x.icache = ic; x.dcache = dc; x.exv = v; x.jal = j; x.jalr = jr;
    x.br = b; x.tk = t; x.ld = l; x.rd = d; x.rs1 = s1; x.rs2 = s2; x.u1 = a1; x.u2 = a2;
    x.pc = p; x.ie = ie; x.ee = ee; x.eb = eb; x.wb = wb; x.nst = ns;
    tbl.push_back(x);
  endfunction

  logic [31:0] ret0;

  initial begin
    reset = 1; rst4 = 1; idle_in();

    // Reset behaviour
    @(negedge clk); #1;
    chk_out("rst", 2'd3, 0, 0, 1, 1);
    chk("rst.state", 32'(state), 0);
    chk("rst.cyc", cyc, 0);
    chk("rst.ret", ret, 0);
    @(negedge clk); reset = 0; #1;
    chk("boot.state", 32'(state), 0);
    chk_out("boot", 2'd3, 1, 1, 1, 1);
    @(negedge clk); #1;
    chk("run.state", 32'(state), 1);
    chk("run.pc_sel", 32'(pc_sel), 0);
    @(negedge clk); #1;
    chk("cyc_after2", cyc, 2);

    // Single-cycle RUN decisions
    //   name          ic dc v  j  jr b  t  l  rd rs1 rs2 u1 u2 pc ie ee eb wb ns
    add("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 1, 0, 0, 1);
    add("br_taken",    0, 0, 1, 0, 0, 1, 1, 0, 0, 0,  0,  0, 0, 1, 1, 1, 1, 0, 2);
    add("br_not",      0, 0, 1, 0, 0, 1, 0, 0, 0, 0,  0,  0, 0, 0, 1, 1, 0, 0, 1);
    add("jal",         0, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 1, 1, 1, 0, 2);
    add("jalr",        0, 0, 1, 0, 1, 0, 0, 0, 0, 0,  0,  0, 0, 2, 1, 1, 1, 0, 2);
    add("jal_invalid", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 1, 0, 0, 1);
    add("lu_rs2",      0, 0, 1, 0, 0, 0, 0, 1, 5, 0,  5,  0, 1, 0, 0, 1, 1, 0, 1);
    add("lu_rs1",      0, 0, 1, 0, 0, 0, 0, 1, 7, 7,  3,  1, 0, 0, 0, 1, 1, 0, 1);
    add("lu_rd0",      0, 0, 1, 0, 0, 0, 0, 1, 0, 0,  0,  1, 1, 0, 1, 1, 0, 0, 1);
    add("lu_unused",   0, 0, 1, 0, 0, 0, 0, 1, 5, 5,  5,  0, 0, 0, 1, 1, 0, 0, 1);
    add("icache",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 1, 0, 1);
    add("icache_jal",  1, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 1);
    add("dcache_jal",  0, 1, 1, 1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 3);
    add("jal_over_lu", 0, 0, 1, 1, 0, 0, 0, 1, 5, 5,  0,  1, 0, 1, 1, 1, 1, 0, 2);

    foreach (tbl[k]) begin
      @(negedge clk); idle_in();
      @(negedge clk);
      @(negedge clk);
      icache = tbl[k].icache; dcache = tbl[k].dcache; exv = tbl[k].exv;
      jal = tbl[k].jal; jalr = tbl[k].jalr; br = tbl[k].br; tk = tbl[k].tk;
      ld = tbl[k].ld; rd = tbl[k].rd; rs1 = tbl[k].rs1; rs2 = tbl[k].rs2;
      u1 = tbl[k].u1; u2 = tbl[k].u2;
      #1;
      chk_out(tbl[k].name, tbl[k].pc, tbl[k].ie, tbl[k].ee, tbl[k].eb, tbl[k].wb);
      @(posedge clk); #1;
      chk({tbl[k].name, ".next"}, 32'(state), 32'(tbl[k].nst));
    end

    // Taken branch then JALR: two-cycle penalty through REDIR
    for (int v = 0; v < 2; v++) begin
      @(negedge clk); idle_in();
      @(negedge clk);
      @(negedge clk); exv = 1; br = (v == 0); tk = (v == 0); jalr = (v == 1); #1;
      chk("redir.pc_sel", 32'(pc_sel), (v == 0) ? 1 : 2);
      chk("redir.ex_bub", 32'(ex_b), 1);
      @(negedge clk); idle_in(); #1;
      chk("redir2.state", 32'(state), 2);
      chk_out("redir2", 2'd0, 1, 1, 1, 0);
      @(negedge clk); #1;
      chk("redir3.state", 32'(state), 1);
    end

    // Load-use: exactly one bubble, then progress
    @(negedge clk); idle_in(); exv = 1; ld = 1; rd = 5; rs2 = 5; u2 = 1; #1;
    chk("lu.if_en", 32'(if_en), 0);
    chk("lu.ex_bub", 32'(ex_b), 1);
    @(negedge clk); exv = 0; #1;
    chk("lu_after.if_en", 32'(if_en), 1);
    chk("lu_after.ex_bub", 32'(ex_b), 0);

    // Data miss during REDIR, returns through REDIR
    @(negedge clk); idle_in(); exv = 1; br = 1; tk = 1;
    @(negedge clk); idle_in(); dcache = 1; wbv = 1; #1;
    chk("mr.state", 32'(state), 2);
    chk_out("mr.frozen", 2'd0, 0, 0, 0, 0);
    ret0 = ret;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin dcache = 0; wbv = 0; end
      #1;
      chk("miss.state", 32'(state), 3);
      chk_out("miss", 2'd0, 0, 0, 0, 0);
      chk("miss.instret", ret, ret0);
    end
    @(negedge clk); #1;
    chk("miss_ret.state", 32'(state), 2);
    chk_out("miss_ret", 2'd0, 1, 1, 1, 0);
    chk("miss_ret.instret", ret, ret0);
    @(negedge clk); #1;
    chk("miss_run.state", 32'(state), 1);

    // Fetch stall together with a redirect: branch held, then taken once
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); idle_in(); icache = 1; exv = 1; br = 1; tk = 1; #1;
      chk("ihold.state", 32'(state), 1);
      chk_out("ihold", 2'd0, 0, 0, 0, 1);
    end
    @(negedge clk); icache = 0; #1;
    chk("irel.pc_sel", 32'(pc_sel), 1);
    ret0 = ret;
    @(negedge clk); idle_in(); wbv = 1; #1;
    chk("irel2.state", 32'(state), 2);
    chk("irel2.pc_sel", 32'(pc_sel), 0);
    @(negedge clk); idle_in(); #1;
    chk("irel.instret", ret, ret0 + 1);

    // Counter wrap on the 4-bit build
    @(negedge clk); rst4 = 0;
    repeat (15) @(posedge clk);
    #1;
    chk("w4.cyc15", 32'(cyc4), 15);
    chk("w4.ret15", 32'(ret4), 15);
    @(posedge clk); #1;
    chk("w4.cyc_wrap", 32'(cyc4), 0);
    chk("w4.ret_wrap", 32'(ret4), 0);

    // Randomized traffic against the reference model
    m_boot = 1; m_kill = 0; m_frozen = 0; m_resume = 0; m_cyc = 0; m_ret = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset  = (i == 0) || ($urandom_range(99) == 0);
      icache = ($urandom_range(4) == 0);
      dcache = ($urandom_range(5) == 0);
      exv    = ($urandom_range(3) != 0);
      jal    = ($urandom_range(7) == 0);
      jalr   = ($urandom_range(7) == 0);
      br     = ($urandom_range(3) == 0);
      tk     = 1'($urandom);
      ld     = ($urandom_range(2) == 0);
      rd     = 5'($urandom_range(3));
      rs1    = 5'($urandom_range(3));
      rs2    = 5'($urandom_range(3));
      u1     = 1'($urandom);
      u2     = 1'($urandom);
      wbv    = 1'($urandom);
      #1;
      model_outputs();
      chk_out("rnd", e_pc, e_if, e_ex, e_exb, e_wbb);
      if (i > 0) begin
        chk("rnd.state", 32'(state), 32'(m_state()));
        chk("rnd.cyc", cyc, m_cyc);
        chk("rnd.ret", ret, m_ret);
      end
      model_advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
